// File: rtl/atri_wb_pkg.sv
// Shared definitions for the ATRI WISHBONE command master: opcodes,
// response status codes, bus widths and the command-path state encoding.
package atri_wb_pkg;

  localparam int ADR_W = 16;
  localparam int DAT_W = 8;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_ERR     = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_RETRY   = 8'h03;
  localparam logic [7:0] ST_BADOP   = 8'h04;

  // BUS covers the whole bus phase as seen by the command path; the
  // one-cycle BACKOFF between retries is tracked inside the cycle engine.
  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADR_HI,
    S_ADR_LO,
    S_WDATA,
    S_BUS,
    S_BACKOFF,
    S_RSP_STATUS,
    S_RSP_DATA
  } state_t;

endpackage

// File: rtl/atri_wb_cycle_engine.sv
// Runs one WISHBONE single cycle per start pulse: drives cyc/stb and the
// latched request, resolves err > ack > rty, applies bounded retry with a
// one-cycle backoff, and abandons the cycle after a stall timeout.
// done is a combinational pulse valid on the edge that ends the cycle.
module atri_wb_cycle_engine
  import atri_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic             req_we,
  input  logic [ADR_W-1:0] req_adr,
  input  logic [DAT_W-1:0] req_dat,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [ADR_W-1:0] wb_adr,
  output logic [DAT_W-1:0] wb_dat_wr,
  input  logic [DAT_W-1:0] wb_dat_rd,
  input  logic             wb_ack,
  input  logic             wb_err,
  input  logic             wb_rty,
  output logic             done,
  output logic [7:0]       status,
  output logic [DAT_W-1:0] rdata
);

  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  logic             cyc_reg;
  logic             backoff_reg;
  logic             we_reg;
  logic [ADR_W-1:0] adr_reg;
  logic [DAT_W-1:0] dat_reg;
  logic [3:0]       retry_cnt_reg;
  logic [15:0]      tmo_cnt_reg;

  logic any_term;
  logic retry_left;
  logic tmo_hit;

  assign any_term   = wb_ack | wb_err | wb_rty;
  assign retry_left = (retry_cnt_reg < RETRY_LIMIT);
  assign tmo_hit    = (tmo_cnt_reg == TMO_LAST);

  // A retry with budget left is not an end of the cycle; everything else
  // that terminates (or the timeout with no termination) is.
  assign done = cyc_reg & (wb_err | wb_ack | (wb_rty & ~retry_left) | (~any_term & tmo_hit));

  // Status resolution with err > ack > rty; timeout only when nothing terminated.
  always_comb begin
    status = ST_TIMEOUT;
    if (wb_err) begin
      status = ST_ERR;
    end else if (wb_ack) begin
      status = ST_OK;
    end else if (wb_rty) begin
      status = ST_RETRY;
    end
  end

  assign rdata     = wb_dat_rd;
  assign wb_cyc    = cyc_reg;
  assign wb_stb    = cyc_reg;
  assign wb_we     = we_reg;
  assign wb_adr    = adr_reg;
  assign wb_dat_wr = dat_reg;

  // Bus cycle sequencing: launch, retry backoff, termination and timeout.
  always_ff @(posedge clk) begin
    if (srst) begin
      cyc_reg       <= 1'b0;
      backoff_reg   <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      dat_reg       <= '0;
      retry_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
    end else if (start) begin
      cyc_reg       <= 1'b1;
      backoff_reg   <= 1'b0;
      we_reg        <= req_we;
      adr_reg       <= req_adr;
      dat_reg       <= req_dat;
      retry_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
    end else if (backoff_reg) begin
      // Reissue the identical request after exactly one idle cycle.
      backoff_reg <= 1'b0;
      cyc_reg     <= 1'b1;
      tmo_cnt_reg <= '0;
    end else if (cyc_reg) begin
      if (wb_err || wb_ack) begin
        cyc_reg <= 1'b0;
      end else if (wb_rty) begin
        cyc_reg <= 1'b0;
        if (retry_left) begin
          retry_cnt_reg <= retry_cnt_reg + 4'd1;
          backoff_reg   <= 1'b1;
        end
      end else if (tmo_hit) begin
        cyc_reg <= 1'b0;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      end
    end
  end

endmodule

// File: rtl/atri_wb_cmd_master.sv
// Byte-stream to WISHBONE initiator. Parses write/read command packets,
// hands the request to the cycle engine on the final byte, and returns a
// status byte (plus a data byte for reads) on the response stream.
module atri_wb_cmd_master
  import atri_wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  cmd_dat_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  output logic [7:0]  rsp_dat_o,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [7:0]  wb_dat_o,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  state_t           state_reg;
  logic             cmd_ready_reg;
  logic             rsp_valid_reg;
  logic [7:0]       rsp_dat_reg;
  logic             is_read_reg;
  logic [7:0]       adr_hi_reg;
  logic [7:0]       adr_lo_reg;
  logic [DAT_W-1:0] rd_data_reg;

  logic             cmd_fire;
  logic             rsp_fire;
  logic             eng_start;
  logic [ADR_W-1:0] eng_adr;
  logic [DAT_W-1:0] eng_dat;
  logic             eng_done;
  logic [7:0]       eng_status;
  logic [DAT_W-1:0] eng_rdata;

  assign cmd_fire = cmd_valid_i & cmd_ready_reg;
  assign rsp_fire = rsp_valid_reg & rsp_ready_i;

  // The request is formed from the byte being accepted so the bus cycle
  // starts on the very next clock after the final command byte.
  assign eng_start = cmd_fire & (((state_reg == S_ADR_LO) & is_read_reg) | (state_reg == S_WDATA));
  assign eng_adr   = (state_reg == S_ADR_LO) ? {adr_hi_reg, cmd_dat_i} : {adr_hi_reg, adr_lo_reg};
  assign eng_dat   = (state_reg == S_WDATA) ? cmd_dat_i : 8'h00;

  atri_wb_cycle_engine #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES)
  ) u_engine (
    .clk      (clk_i),
    .srst     (rst_i),
    .start    (eng_start),
    .req_we   (~is_read_reg),
    .req_adr  (eng_adr),
    .req_dat  (eng_dat),
    .wb_cyc   (wb_cyc_o),
    .wb_stb   (wb_stb_o),
    .wb_we    (wb_we_o),
    .wb_adr   (wb_adr_o),
    .wb_dat_wr(wb_dat_o),
    .wb_dat_rd(wb_dat_i),
    .wb_ack   (wb_ack_i),
    .wb_err   (wb_err_i),
    .wb_rty   (wb_rty_i),
    .done     (eng_done),
    .status   (eng_status),
    .rdata    (eng_rdata)
  );

  assign cmd_ready_o = cmd_ready_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_dat_o   = rsp_dat_reg;

  // Command parsing and response sequencing with registered handshake outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= S_OPCODE;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= 8'h00;
      is_read_reg   <= 1'b0;
      adr_hi_reg    <= 8'h00;
      adr_lo_reg    <= 8'h00;
      rd_data_reg   <= 8'h00;
    end else begin
      case (state_reg)
        S_OPCODE: begin
          cmd_ready_reg <= 1'b1;
          if (cmd_fire) begin
            if ((cmd_dat_i == OP_WRITE) || (cmd_dat_i == OP_READ)) begin
              is_read_reg <= (cmd_dat_i == OP_READ);
              state_reg   <= S_ADR_HI;
            end else begin
              is_read_reg   <= 1'b0;
              cmd_ready_reg <= 1'b0;
              rsp_valid_reg <= 1'b1;
              rsp_dat_reg   <= ST_BADOP;
              state_reg     <= S_RSP_STATUS;
            end
          end
        end
        S_ADR_HI: begin
          if (cmd_fire) begin
            adr_hi_reg <= cmd_dat_i;
            state_reg  <= S_ADR_LO;
          end
        end
        S_ADR_LO: begin
          if (cmd_fire) begin
            adr_lo_reg <= cmd_dat_i;
            if (is_read_reg) begin
              cmd_ready_reg <= 1'b0;
              state_reg     <= S_BUS;
            end else begin
              state_reg <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (cmd_fire) begin
            cmd_ready_reg <= 1'b0;
            state_reg     <= S_BUS;
          end
        end
        S_BUS: begin
          if (eng_done) begin
            rsp_valid_reg <= 1'b1;
            rsp_dat_reg   <= eng_status;
            rd_data_reg   <= (eng_status == ST_OK) ? eng_rdata : 8'h00;
            state_reg     <= S_RSP_STATUS;
          end
        end
        S_RSP_STATUS: begin
          if (rsp_fire) begin
            if (is_read_reg) begin
              rsp_dat_reg <= rd_data_reg;
              state_reg   <= S_RSP_DATA;
            end else begin
              rsp_valid_reg <= 1'b0;
              rsp_dat_reg   <= 8'h00;
              cmd_ready_reg <= 1'b1;
              state_reg     <= S_OPCODE;
            end
          end
        end
        S_RSP_DATA: begin
          if (rsp_fire) begin
            rsp_valid_reg <= 1'b0;
            rsp_dat_reg   <= 8'h00;
            cmd_ready_reg <= 1'b1;
            state_reg     <= S_OPCODE;
          end
        end
        default: begin
          state_reg <= S_OPCODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atri_wb_cmd_master.sv
// Randomized and directed bench for atri_wb_cmd_master with a scripted
// slave and a packet-level reference model of the expected responses.
module tb_atri_wb_cmd_master;
  import atri_wb_pkg::*;

  localparam int TO = 8;
  localparam int MR = 3;
  localparam int K_ACK = 0, K_ERR = 1, K_NONE = 2, K_RTY = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  cmd_dat_i = 8'h00;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [7:0]  rsp_dat_o;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o;
  logic [7:0]  wb_dat_o;
  logic [7:0]  wb_dat_i;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  always #5 clk_i = ~clk_i;

  atri_wb_cmd_master #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_dat_i(cmd_dat_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .rsp_dat_o(rsp_dat_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;

  // Slave script for the current transaction.
  int          sl_nrty = 0, sl_kind = K_ACK, sl_t = 1;
  logic [7:0]  sl_rdat = 8'h00;
  logic        sl_we = 1'b0;
  logic [15:0] sl_adr = 16'h0000;
  logic [7:0]  sl_dat = 8'h00;

  int attempts = 0, in_att = 0, hi_cnt = 0, gap_cnt = 0, rise_cyc = 0;
  int acc_cyc = 0, valid_rise_cyc = 0, rdy_mode = 0, hold_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] capb(input int i);
    logic [7:0] v;
    v = 8'hxx;
    if (i < cap_q.size()) v = cap_q[i];
    return v;
  endfunction

  // Packet-level outcome of a bus request given the slave script.
  function automatic void model(input int nrty, input int kind, input int t,
                                output logic [7:0] st, output int att);
    att = 0;
    st  = ST_TIMEOUT;
    for (int k = 0; k < 16; k++) begin
      att++;
      if (t > TO) begin st = ST_TIMEOUT; break; end
      if (k < nrty) begin
        if (k < MR) continue;
        st = ST_RETRY;
        break;
      end
      if (kind == K_ACK) st = ST_OK;
      else if (kind == K_ERR) st = ST_ERR;
      else st = ST_TIMEOUT;
      break;
    end
  endfunction

  function automatic int exp_len(input int k);
    int kind;
    kind = (k < sl_nrty) ? K_RTY : sl_kind;
    return (kind == K_NONE || sl_t > TO) ? TO : sl_t;
  endfunction

  // Scripted slave: terminates on the configured strobe cycle, drives
  // random terminations while stb is low, and checks the bus request.
  initial begin
    int k, kind;
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = 0;
    forever begin
      @(negedge clk_i);
      wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
      chk("cyc_eq_stb", wb_cyc_o, wb_stb_o);
      if (rst_i) begin
        in_att = 0;
        wb_dat_i = 8'h00;
      end else if (wb_stb_o) begin
        if (in_att == 0) begin
          if (attempts > 0) chk("backoff_gap", gap_cnt, 1);
          attempts++;
          in_att = 1;
          hi_cnt = 0;
          rise_cyc = cyc_n;
        end
        hi_cnt++;
        chk("bus_we", wb_we_o, sl_we);
        chk("bus_adr", wb_adr_o, sl_adr);
        if (sl_we) chk("bus_dat", wb_dat_o, sl_dat);
        chk("cmd_ready_busy", cmd_ready_o, 0);
        k = attempts - 1;
        kind = (k < sl_nrty) ? K_RTY : sl_kind;
        wb_dat_i = 8'($urandom);
        if (hi_cnt == sl_t) begin
          if (kind == K_ACK) begin wb_ack_i = 1; wb_dat_i = sl_rdat; end
          else if (kind == K_ERR) wb_err_i = 1;
          else if (kind == K_RTY) wb_rty_i = 1;
        end
      end else begin
        if (in_att != 0) begin
          in_att = 0;
          chk("stb_len", hi_cnt, exp_len(attempts - 1));
          gap_cnt = 0;
        end
        gap_cnt++;
        wb_ack_i = ($urandom % 4) == 0;
        wb_err_i = ($urandom % 4) == 0;
        wb_rty_i = ($urandom % 4) == 0;
        wb_dat_i = 8'($urandom);
      end
    end
  end

  // Response sink readiness.
  initial begin
    rsp_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (rdy_mode == 0) rsp_ready_i = 1'b1;
      else if (rdy_mode == 1) rsp_ready_i = ($urandom % 2) == 1;
      else begin
        rsp_ready_i = (hold_cnt >= 5);
        if (rsp_valid_o) hold_cnt++;
      end
    end
  end

  // Response compare against the model queue plus backpressure stability.
  initial begin
    logic prev_stall, prev_valid;
    logic [7:0] prev_dat, e;
    prev_stall = 0; prev_valid = 0; prev_dat = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall = 0;
        prev_valid = 0;
      end else begin
        if (prev_stall) begin
          chk("bp_valid", rsp_valid_o, 1);
          chk("bp_data", rsp_dat_o, prev_dat);
        end
        if (rsp_valid_o && !prev_valid) valid_rise_cyc = cyc_n;
        if (rsp_valid_o && rsp_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_extra got=0x%0h expected=none", rsp_dat_o);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_byte", rsp_dat_o, e);
          end
          cap_q.push_back(rsp_dat_o);
        end
        prev_stall = rsp_valid_o && !rsp_ready_i;
        prev_valid = rsp_valid_o;
        prev_dat   = rsp_dat_o;
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin @(posedge clk_i); #1; end
    cmd_valid_i = 1'b1;
    cmd_dat_i   = b;
    n = 0;
    forever begin
      @(negedge clk_i);
      if (cmd_ready_o) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL cmd_ready_wait got=0 expected=1");
        break;
      end
    end
    @(posedge clk_i);
    #1;
    acc_cyc     = cyc_n;
    cmd_valid_i = 1'b0;
    cmd_dat_i   = 8'($urandom);
  endtask

  task automatic run_cmd(input logic [7:0] op, input logic [15:0] adr, input logic [7:0] dat,
                         input int nrty, input int kind, input int t, input logic [7:0] rdat,
                         input int maxgap);
    logic [7:0] st;
    int att, n;
    bit ok, rd;
    ok = (op == OP_WRITE) || (op == OP_READ);
    rd = (op == OP_READ);
    sl_nrty = nrty; sl_kind = kind; sl_t = t; sl_rdat = rdat;
    sl_we = (op == OP_WRITE); sl_adr = adr; sl_dat = dat;
    attempts = 0;
    hold_cnt = 0;
    cap_q.delete();
    if (ok) model(nrty, kind, t, st, att);
    else begin st = ST_BADOP; att = 0; end
    exp_q.push_back(st);
    if (ok && rd) exp_q.push_back((st == ST_OK) ? rdat : 8'h00);
    send_byte(op, $urandom_range(0, maxgap));
    if (ok) begin
      send_byte(adr[15:8], $urandom_range(0, maxgap));
      send_byte(adr[7:0], $urandom_range(0, maxgap));
      if (!rd) send_byte(dat, $urandom_range(0, maxgap));
    end
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid_o) && n < 3000) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL rsp_wait got=%0d_pending expected=0", exp_q.size());
      exp_q.delete();
    end
    chk("strobes", attempts, att);
    $display("txn op=%02h adr=%04h dat=%02h nrty=%0d kind=%0d t=%0d -> status=%02h strobes=%0d bytes=%0d",
             op, adr, dat, nrty, kind, t, st, attempts, cap_q.size());
  endtask

  initial begin
    int n;
    logic [7:0] op;
    // Reset values.
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_cmd_ready", cmd_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_dat", rsp_dat_o, 8'h00);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 16'h0000);
    chk("rst_dat", wb_dat_o, 8'h00);
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Write with ack on the second strobe cycle.
    run_cmd(OP_WRITE, 16'h0012, 8'hA5, 0, K_ACK, 2, 8'h00, 0);
    chk("wr_bytes", cap_q.size(), 1);
    chk("wr_status", capb(0), 8'h00);
    chk("wr_strobes", attempts, 1);

    // Read with immediate ack, minimum latency.
    run_cmd(OP_READ, 16'h0040, 8'h00, 0, K_ACK, 1, 8'h3C, 0);
    chk("rd_status", capb(0), 8'h00);
    chk("rd_data", capb(1), 8'h3C);
    chk("rd_stb_delay", rise_cyc - acc_cyc + 1, 1);
    chk("rd_rsp_delay", valid_rise_cyc - acc_cyc + 1, 2);

    // Three retries then ack; four retries exhaust.
    run_cmd(OP_READ, 16'h0100, 8'h00, 3, K_ACK, 1, 8'h77, 0);
    chk("rty3_strobes", attempts, 4);
    chk("rty3_status", capb(0), 8'h00);
    chk("rty3_data", capb(1), 8'h77);
    run_cmd(OP_READ, 16'h0101, 8'h00, 4, K_ACK, 1, 8'h77, 0);
    chk("rty4_status", capb(0), 8'h03);
    chk("rty4_data", capb(1), 8'h00);

    // Timeout, and err on the last cycle before timeout.
    run_cmd(OP_READ, 16'hBEEF, 8'h00, 0, K_NONE, 20, 8'h11, 0);
    chk("tmo_status", capb(0), 8'h02);
    chk("tmo_data", capb(1), 8'h00);
    run_cmd(OP_READ, 16'hBEF0, 8'h00, 0, K_ERR, 8, 8'h11, 0);
    chk("err8_status", capb(0), 8'h01);
    chk("err8_data", capb(1), 8'h00);

    // Bad opcode, then a read under held-off response ready.
    run_cmd(8'h7F, 16'h0000, 8'h00, 0, K_ACK, 1, 8'h00, 0);
    chk("bad_bytes", cap_q.size(), 1);
    chk("bad_status", capb(0), 8'h04);
    chk("bad_strobes", attempts, 0);
    rdy_mode = 2;
    run_cmd(OP_READ, 16'h0042, 8'h00, 0, K_ACK, 3, 8'h5A, 0);
    chk("bp_rd_data", capb(1), 8'h5A);
    rdy_mode = 0;

    // Reset while strobing mid-retry, then a clean write.
    sl_nrty = 100; sl_kind = K_ACK; sl_t = 3; sl_we = 1'b0; sl_adr = 16'h1234;
    attempts = 0;
    send_byte(OP_READ, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    n = 0;
    while (!(attempts >= 2 && wb_stb_o) && n < 200) begin
      @(negedge clk_i); #1; n++;
    end
    chk("rst_mid_reached", (n < 200) ? 1 : 0, 1);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i); #1;
    chk("midrst_cyc", wb_cyc_o, 0);
    chk("midrst_stb", wb_stb_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    rst_i = 1'b0;
    exp_q.delete();
    @(posedge clk_i); #1;
    run_cmd(OP_WRITE, 16'h5678, 8'h9A, 0, K_ACK, 1, 8'h00, 1);
    chk("post_rst_status", capb(0), 8'h00);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      n = $urandom % 10;
      if (n < 4) op = OP_WRITE;
      else if (n < 8) op = OP_READ;
      else if (n == 8) op = 8'h00;
      else op = 8'hFF;
      rdy_mode = $urandom % 2;
      run_cmd(op, 16'($urandom), 8'($urandom), $urandom % 6, $urandom % 3,
              $urandom_range(1, 10), 8'($urandom), 2);
    end
    rdy_mode = 0;
    repeat (4) @(posedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
